// File: rtl/cache_miss_sequencer.sv
// Miss sequencer for a direct-mapped write-back data cache in front of a
// multi-cycle main memory. Handles hits in a single cycle. On a miss it
// optionally writes back the dirty victim, then fills the line, then returns
// to IDLE so that the request completes as a hit.
module cache_miss_sequencer #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    input  logic             halted,
    output logic             req_ready,
    output logic             cache_we,
    output logic             cache_input_type,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             mem_write_en,
    output logic             memory_address_type,
    output logic             busy,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    // The memory-access counter runs from MEM_LATENCY-1 down to 0, so one
    // phase lasts exactly MEM_LATENCY cycles.
    localparam logic [7:0] CNT_INIT = 8'(MEM_LATENCY - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;

    // State, access counter and statistics registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            miss_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            wb_q    <= wb_d;
        end
    end

    // Next state and strobes. IDLE is Mealy on the request; WB and FILL are
    // Moore and ignore the core's inputs until the sequence completes.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        miss_d              = miss_q;
        wb_d                = wb_q;
        req_ready           = 1'b0;
        cache_we            = 1'b0;
        cache_input_type    = 1'b0;
        set_valid           = 1'b0;
        set_dirty           = 1'b0;
        mem_write_en        = 1'b0;
        memory_address_type = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (cache_hit) begin
                        req_ready = 1'b1;
                        if (req_write) begin
                            cache_we         = 1'b1;
                            cache_input_type = 1'b1;
                            set_valid        = 1'b1;
                            set_dirty        = 1'b1;
                        end
                    end else if (!halted) begin
                        // Counters stick at all-ones rather than wrapping.
                        if (miss_q != {CNT_W{1'b1}})
                            miss_d = miss_q + CNT_W'(1);
                        cnt_d = CNT_INIT;
                        if (cache_dirty) begin
                            state_d = WB;
                            if (wb_q != {CNT_W{1'b1}})
                                wb_d = wb_q + CNT_W'(1);
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end

            WB: begin
                mem_write_en        = 1'b1;
                memory_address_type = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = FILL;
                    cnt_d   = CNT_INIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            FILL: begin
                if (cnt_q == 8'd0) begin
                    // Memory data is ready on the last cycle. Install a clean line.
                    cache_we  = 1'b1;
                    set_valid = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

endmodule
